// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader packing little-endian words into a 64-word program
// memory, holding the CPU in reset until the programmed length is written.
module imem_loader #(
  parameter int WORDS = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        cpu_hold,
  output logic        loading,
  output logic        done,
  output logic        err,
  output logic [6:0]  words_loaded,
  input  logic [31:0] addr,
  output logic [31:0] instr
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2;
  logic [1:0]  state_q, state_d, lane_q, lane_d;
  logic [23:0] hold_q, hold_d;
  logic [6:0]  wl_q, wl_d, num_q, num_d;
  logic        err_q, err_d, legal, take, wr;
  logic [31:0] mem [WORDS];
  logic        unused_addr;
  always_comb begin
    legal   = num_words != 7'd0 && num_words <= 7'(WORDS);
    take    = byte_valid && state_q == S_LOAD;
    wr      = take && lane_q == 2'd3;
    state_d = state_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    wl_d    = wl_q;
    num_d   = num_q;
    err_d   = err_q;
    if (start && state_q != S_LOAD) begin
      state_d = legal ? S_LOAD : state_q;
      err_d   = !legal;
      lane_d  = legal ? 2'd0 : lane_q;
      wl_d    = legal ? 7'd0 : wl_q;
      num_d   = legal ? num_words : num_q;
    end
    if (take) begin
      lane_d        = lane_q + 2'd1;
      hold_d[7:0]   = lane_q == 2'd0 ? byte_in : hold_q[7:0];
      hold_d[15:8]  = lane_q == 2'd1 ? byte_in : hold_q[15:8];
      hold_d[23:16] = lane_q == 2'd2 ? byte_in : hold_q[23:16];
    end
    if (wr) begin
      wl_d    = wl_q + 7'd1;
      state_d = wl_q + 7'd1 == num_q ? S_DONE : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      hold_q  <= 24'd0;
      wl_q    <= 7'd0;
      num_q   <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      wl_q    <= wl_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end
  // Memory has no reset: contents survive controller resets and reloads.
  always_ff @(posedge clk) begin
    if (wr && !reset) mem[wl_q[AW-1:0]] <= {byte_in, hold_q};
  end
  assign instr        = mem[addr[AW+1:2]];
  assign unused_addr  = ^{addr[31:AW+2], addr[1:0]};
  assign byte_ready   = state_q == S_LOAD;
  assign loading      = state_q == S_LOAD;
  assign done         = state_q == S_DONE;
  assign cpu_hold     = state_q != S_DONE;
  assign err          = err_q;
  assign words_loaded = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven and randomized checks of imem_loader
// against a word-array model of program memory.
module tb_imem_loader;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [6:0]  num_words = 7'd0;
  logic [7:0]  byte_in = 8'd0;
  logic [31:0] addr = 32'd0;
  logic        byte_ready, cpu_hold, loading, done, err;
  logic [6:0]  words_loaded;
  logic [31:0] instr;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mm [64];
  bit          mk [64];
  logic [7:0]  bq [$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cpu_hold(cpu_hold), .loading(loading), .done(done), .err(err),
    .words_loaded(words_loaded), .addr(addr), .instr(instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_load(input logic [6:0] n);
    start = 1'b1;
    num_words = n;
    tick();
    start = 1'b0;
  endtask

  // Drives bq through the handshake; rnd adds random valid gaps and ignored start pulses.
  task automatic feed(input bit rnd, input bit toggle, output int cyc);
    int idx = 0;
    bit acc;
    cyc = 0;
    while (idx < bq.size() && cyc < 4 * bq.size() * 20 + 100) begin
      byte_valid = rnd ? 1'($urandom) : toggle ? 1'(cyc % 2 == 0) : 1'b1;
      byte_in = bq[idx];
      if (rnd) begin
        start = ($urandom % 8) == 0;
        num_words = 7'($urandom);
      end
      if (cyc == 0 || byte_ready !== 1'b1) check("ready_in_load", {31'd0, byte_ready}, 32'd1);
      acc = byte_valid && byte_ready;
      tick();
      cyc++;
      if (acc) idx++;
      if (idx < bq.size() && done !== 1'b0) check("done_early", {31'd0, done}, 32'd0);
    end
    start = 1'b0;
    byte_valid = 1'b0;
    if (idx < bq.size()) check("feed_timeout", 32'(idx), 32'(bq.size()));
  endtask

  task automatic commit(input int words);
    for (int i = 0; i < words; i++) begin
      mm[i] = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
      mk[i] = 1'b1;
    end
  endtask

  task automatic chk_mem();
    for (int i = 0; i < 64; i++) begin
      if (mk[i]) begin
        addr = ($urandom() & 32'hFFFF_FF00) | (i << 2) | ($urandom() % 4);
        #1;
        check($sformatf("mem[%0d]", i), instr, mm[i]);
      end
    end
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
  endtask

  typedef struct {
    logic [6:0] n;
    logic       exp_err;
    logic       exp_rdy;
    bit         rst_after;
  } vec_t;

  initial begin
    vec_t vt[6];
    int cyc;
    int n;
    vt[0] = '{7'd0,   1'b1, 1'b0, 1'b0};
    vt[1] = '{7'd65,  1'b1, 1'b0, 1'b0};
    vt[2] = '{7'd1,   1'b0, 1'b1, 1'b1};
    vt[3] = '{7'd127, 1'b1, 1'b0, 1'b0};
    vt[4] = '{7'd64,  1'b0, 1'b1, 1'b1};
    vt[5] = '{7'd0,   1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 64; i++) mk[i] = 1'b0;

    do_reset();
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_loading", {31'd0, loading}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wl", {25'd0, words_loaded}, 32'd0);

    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    start_load(7'd2);
    check("load_hold", {31'd0, cpu_hold}, 32'd1);
    check("load_loading", {31'd0, loading}, 32'd1);
    feed(1'b0, 1'b0, cyc);
    check("b2b_cycles", 32'(cyc), 32'd8);
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_hold", {31'd0, cpu_hold}, 32'd1 ^ 32'd1);
    check("b2b_ready", {31'd0, byte_ready}, 32'd0);
    check("b2b_wl", {25'd0, words_loaded}, 32'd2);
    addr = 32'd0; #1; check("instr_a0", instr, 32'h12345678);
    addr = 32'd4; #1; check("instr_a4", instr, 32'hDEADBEEF);
    addr = 32'd5; #1; check("instr_a5", instr, 32'hDEADBEEF);
    commit(2);

    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    start_load(7'd2);
    check("reload_hold", {31'd0, cpu_hold}, 32'd1);
    feed(1'b0, 1'b1, cyc);
    check("toggle_done", {31'd0, done}, 32'd1);
    check("toggle_wl", {25'd0, words_loaded}, 32'd2);
    commit(2);
    chk_mem();

    do_reset();
    for (int i = 0; i < 6; i++) begin
      start_load(vt[i].n);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vt[i].exp_err});
      check($sformatf("vec%0d_ready", i), {31'd0, byte_ready}, {31'd0, vt[i].exp_rdy});
      check($sformatf("vec%0d_loading", i), {31'd0, loading}, {31'd0, vt[i].exp_rdy});
      check($sformatf("vec%0d_hold", i), {31'd0, cpu_hold}, 32'd1);
      if (vt[i].rst_after) do_reset();
    end
    do_reset();

    bq.delete();
    for (int i = 0; i < 64; i++) for (int b = 0; b < 4; b++) bq.push_back(8'(i));
    start_load(7'd64);
    feed(1'b0, 1'b0, cyc);
    check("full_cycles", 32'(cyc), 32'd256);
    check("full_done", {31'd0, done}, 32'd1);
    check("full_wl", {25'd0, words_loaded}, 32'd64);
    addr = 32'hFC; #1; check("full_fc", instr, 32'h3F3F3F3F);
    addr = 32'h100; #1; check("full_wrap", instr, 32'h00000000);
    commit(64);
    chk_mem();

    bq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    start_load(7'd2);
    feed(1'b0, 1'b0, cyc);
    check("partial_done", {31'd0, done}, 32'd0);
    do_reset();
    check("abort_ready", {31'd0, byte_ready}, 32'd0);
    check("abort_loading", {31'd0, loading}, 32'd0);
    check("abort_hold", {31'd0, cpu_hold}, 32'd1);
    check("abort_wl", {25'd0, words_loaded}, 32'd0);
    commit(1);
    chk_mem();
    bq = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    start_load(7'd1);
    feed(1'b0, 1'b0, cyc);
    check("w1_done", {31'd0, done}, 32'd1);
    addr = 32'd0; #1; check("w1_word0", instr, 32'hAABBCCDD);
    addr = 32'd4; #1; check("w1_word1", instr, 32'h01010101);
    commit(1);

    start_load(7'd100);
    check("done_bad_err", {31'd0, err}, 32'd1);
    check("done_bad_stay", {31'd0, done}, 32'd1);
    rand_bytes(1);
    start_load(7'd1);
    check("redo_hold", {31'd0, cpu_hold}, 32'd1);
    check("redo_err", {31'd0, err}, 32'd0);
    feed(1'b0, 1'b0, cyc);
    check("redo_done", {31'd0, done}, 32'd1);
    commit(1);
    chk_mem();

    for (int k = 0; k < 8; k++) begin
      n = (k == 0) ? 64 : int'($urandom_range(1, 12));
      rand_bytes(n);
      start_load(7'(n));
      feed(1'b1, 1'b0, cyc);
      check("rnd_done", {31'd0, done}, 32'd1);
      check("rnd_wl", {25'd0, words_loaded}, 32'(n));
      commit(n);
      chk_mem();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writable program memory with a byte-stream loader: the write side of the processor's 64-word instruction store. It accepts program bytes over a valid/ready handshake, packs them little-endian into 32-bit words, and writes them sequentially from word 0. It holds the processor in reset until the programmed length has been written. The fetch side is an asynchronous, word-aligned read port, so the processor fetches exactly as from a ROM once loading completes.

## Interface
- WORDS, 64, depth of program memory in 32-bit words
- AW, 6, word-index width (log2 WORDS)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears controller state only, not memory contents
- start  input  1  single-cycle pulse requesting a (re)load
- num_words  input  7  program length in words, sampled when start is accepted; legal range 1..WORDS
- byte_in  input  8  program byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader can accept a byte this cycle
- cpu_hold  output  1  processor reset request; 1 until a load completes
- loading  output  1  load in progress
- done  output  1  load complete, program runnable
- err  output  1  sticky: last start had an illegal num_words
- words_loaded  output  7  count of words written in the current or last load
- addr  input  32  fetch byte address; bits [1:0] ignored, word index = addr[AW+1:2]
- instr  output  32  memory word at word index, combinational

## Operation
- States: IDLE, LOAD, DONE. Reset → IDLE.
- IDLE: byte_ready=0, cpu_hold=1. start with num_words in 1..64 → LOAD, clear words_loaded, byte lane and word pointer, clear err. start with num_words 0 or >64 → stay IDLE, err=1.
- LOAD: byte_ready=1, loading=1, cpu_hold=1. Byte accepted when byte_valid && byte_ready. Lane counter 0..3 selects destination bits: lane 0 → [7:0], lane 1 → [15:8], lane 2 → [23:16], lane 3 → [31:24].
- On acceptance of a lane-3 byte: write {byte_in, held lanes 2..0} to memory[word pointer] at that edge; increment word pointer and words_loaded; lane resets to 0.
- When that write makes words_loaded equal the sampled num_words → DONE at the same edge.
- start is ignored in LOAD.
- DONE: done=1, cpu_hold=0, byte_ready=0. start with a legal length → LOAD (cpu_hold reasserts next cycle). start with an illegal length → stay DONE, err=1.
- Memory is never cleared. Words at or beyond num_words keep their prior contents. There are no byte-granular partial writes; a word is written only when complete.
- Read port: instr = memory[addr[AW+1:2]], independent of state. Upper address bits beyond AW+1 are ignored (wrap).

## Timing
- Reset values: byte_ready=0, cpu_hold=1, loading=0, done=0, err=0, words_loaded=0. Memory unchanged.
- Throughput: one byte per cycle while byte_valid is held high. An N-word load takes 4N accepting cycles after the start cycle.
- start accepted at edge t → byte_ready=1 from cycle t+1.
- Final byte accepted at edge t → done=1, cpu_hold=0, byte_ready=0 from cycle t+1.
- Written word is visible on instr (for a matching addr) from the cycle after its write edge. Same-cycle read-during-write returns the old word.
- byte_valid low stalls with no state change. The partial word is held indefinitely.
- Reset mid-LOAD: next cycle IDLE, held partial bytes discarded, already-written words retained, words_loaded=0.
- start and reset in the same cycle: reset wins.

## Test plan
- Reset, then start with num_words=2 and bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE back-to-back → done at cycle 9 after start. addr=0 → instr=0x12345678; addr=4 → 0xDEADBEEF; addr=5 → 0xDEADBEEF; words_loaded=2.
- Same load with byte_valid toggling every other cycle → identical memory contents. done arrives 8 accepted bytes later, and no byte is lost or duplicated.
- start with num_words=0, then with num_words=65 → err=1, state stays IDLE, byte_ready=0, cpu_hold=1. A following legal start clears err.
- Full 64-word load of pattern word i = i*0x01010101 → done, words_loaded=64. addr=0xFC → 0x3F3F3F3F; addr=0x100 wraps → instr=0x00000000.
- Reset asserted after 6 bytes of a 2-word load → IDLE, word 0 written, word 1 unchanged. A reload of 1 word with 0xAABBCCDD overwrites word 0 only.
- Reload from DONE with num_words=1 → cpu_hold=1 during LOAD, word 0 replaced, word 1 retains its previous value, done reasserts.
